// File: rtl/bcd_stopwatch_core_pkg.sv
// Shared definitions for the MM:SS BCD stopwatch: state encodings, digit limits
// and the BCD increment used by the live counter.
package bcd_stopwatch_core_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_FULL  = 2'd3;

    localparam logic [3:0] SEC_U_MAX = 4'd9;
    localparam logic [3:0] SEC_T_MAX = 4'd5;
    localparam logic [3:0] MIN_U_MAX = 4'd9;
    localparam logic [3:0] MIN_T_MAX = 4'd5;

    // Digit order: [3] minutes tens, [2] minutes units, [1] seconds tens, [0] seconds units.
    typedef logic [3:0][3:0] bcd4_t;

    localparam bcd4_t BCD_MAX = {MIN_T_MAX, MIN_U_MAX, SEC_T_MAX, SEC_U_MAX};

    // Caller guarantees v != BCD_MAX, so the minutes-tens digit never exceeds 5.
    function automatic bcd4_t bcd_inc(input bcd4_t v);
        bcd4_t r;
        r = v;
        if (v[0] == SEC_U_MAX) begin
            r[0] = '0;
            if (v[1] == SEC_T_MAX) begin
                r[1] = '0;
                if (v[2] == MIN_U_MAX) begin
                    r[2] = '0;
                    r[3] = v[3] + 4'd1;
                end else begin
                    r[2] = v[2] + 4'd1;
                end
            end else begin
                r[1] = v[1] + 4'd1;
            end
        end else begin
            r[0] = v[0] + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_stopwatch_core_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV enabled cycles.
// The count is held while en is low and forced to zero by clr.
module stopwatch_tick_gen #(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter int unsigned TICK_W   = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    logic [TICK_W-1:0] cnt_q, cnt_d;
    logic              wrap;

    assign wrap = (cnt_q == TICK_W'(TICK_DIV - 1));
    assign tick = en && wrap;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = wrap ? '0 : cnt_q + TICK_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bcd_stopwatch_core.sv
// MM:SS stopwatch: control FSM, BCD live counter, lap snapshot and registered
// digit outputs feeding the 7-segment scan stage.
module bcd_stopwatch_core
    import bcd_stopwatch_core_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter int unsigned TICK_W   = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clr,
    output logic [3:0] cnt3,
    output logic [3:0] cnt2,
    output logic [3:0] cnt1,
    output logic [3:0] cnt0,
    output logic       running,
    output logic       full,
    output logic       lap_hold
);

    logic [1:0] state_q, state_d;
    bcd4_t      live_q, live_d;
    bcd4_t      snap_q, snap_d;
    bcd4_t      disp_q, disp_d;
    logic       hold_q, hold_d;
    logic       tick;
    logic       clr_act;

    // Prescaler sits at zero throughout IDLE, so every IDLE->RUN starts a full period.
    stopwatch_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .TICK_W   (TICK_W)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == ST_RUN),
        .clr  (state_q == ST_IDLE),
        .tick (tick)
    );

    assign clr_act = clr && (state_q != ST_RUN);

    always_comb begin
        state_d = state_q;
        live_d  = live_q;
        snap_d  = snap_q;
        hold_d  = hold_q;

        if (clr_act) begin
            state_d = ST_IDLE;
            live_d  = '0;
            hold_d  = 1'b0;
        end else if (start_stop) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = state_q;
            endcase
        end else if (lap) begin
            case (state_q)
                ST_RUN: begin
                    if (!hold_q) begin
                        snap_d = live_q;
                        hold_d = 1'b1;
                    end else begin
                        hold_d = 1'b0;
                    end
                end
                ST_PAUSE, ST_FULL: hold_d = 1'b0;
                default:           hold_d = hold_q;
            endcase
        end

        // Ticks only occur in RUN, where clr is inert; saturation overrides a same-edge pause.
        if (tick) begin
            if (live_q == BCD_MAX) begin
                state_d = ST_FULL;
                hold_d  = 1'b0;
            end else begin
                live_d = bcd_inc(live_q);
            end
        end

        disp_d = hold_d ? snap_d : live_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            live_q  <= '0;
            snap_q  <= '0;
            disp_q  <= '0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= live_d;
            snap_q  <= snap_d;
            disp_q  <= disp_d;
            hold_q  <= hold_d;
        end
    end

    assign {cnt3, cnt2, cnt1, cnt0} = disp_q;
    assign running  = (state_q == ST_RUN);
    assign full     = (state_q == ST_FULL);
    assign lap_hold = hold_q;

endmodule

// File: tb/tb_bcd_stopwatch_core.sv
// Scoreboard bench: an elapsed-seconds reference model predicts each cycle's
// outputs; a negedge monitor pops and compares them against the DUT.
module tb_bcd_stopwatch_core;

    localparam int unsigned DIV = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_FULL  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_stop = 1'b0;
    logic       lap = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] cnt3, cnt2, cnt1, cnt0;
    logic       running, full, lap_hold;

    always #5 clk = ~clk;

    bcd_stopwatch_core #(
        .TICK_DIV (DIV),
        .TICK_W   (27)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .lap        (lap),
        .clr        (clr),
        .cnt3       (cnt3),
        .cnt2       (cnt2),
        .cnt1       (cnt1),
        .cnt0       (cnt0),
        .running    (running),
        .full       (full),
        .lap_hold   (lap_hold)
    );

    typedef struct {
        logic [15:0] dig;
        logic [2:0]  flg;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cycle    = 0;

    // Reference model: elapsed whole seconds plus a prescaler phase.
    int m_st   = M_IDLE;
    int m_secs = 0;
    int m_snap = 0;
    int m_pre  = 0;
    bit m_hold = 1'b0;

    function automatic logic [15:0] to_digits(input int v);
        int mm, ss;
        mm = v / 60;
        ss = v % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic model_step(input bit r, input bit s, input bit l, input bit c);
        bit tk;
        if (r) begin
            m_st = M_IDLE; m_secs = 0; m_snap = 0; m_pre = 0; m_hold = 1'b0;
            return;
        end
        tk = (m_st == M_RUN) && (m_pre == int'(DIV) - 1);
        if (m_st == M_RUN) m_pre = (m_pre + 1) % int'(DIV);
        if (c && m_st != M_RUN) begin
            m_st = M_IDLE; m_secs = 0; m_hold = 1'b0;
        end else if (s) begin
            if (m_st == M_IDLE) begin
                m_st = M_RUN; m_pre = 0;
            end else if (m_st == M_RUN) begin
                m_st = M_PAUSE;
            end else if (m_st == M_PAUSE) begin
                m_st = M_RUN;
            end
        end else if (l) begin
            if (m_st == M_RUN) begin
                if (!m_hold) begin
                    m_snap = m_secs; m_hold = 1'b1;
                end else begin
                    m_hold = 1'b0;
                end
            end else if (m_st != M_IDLE) begin
                m_hold = 1'b0;
            end
        end
        if (tk) begin
            if (m_secs == 59 * 60 + 59) begin
                m_st = M_FULL; m_hold = 1'b0;
            end else begin
                m_secs++;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit s, input bit l, input bit c);
        exp_t e;
        rst = r; start_stop = s; lap = l; clr = c;
        @(posedge clk);
        model_step(r, s, l, c);
        e.dig = m_hold ? to_digits(m_snap) : to_digits(m_secs);
        e.flg = {m_st == M_RUN, m_st == M_FULL, m_hold};
        e.cyc = cycle;
        sb.push_back(e);
        cycle++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        $display("FAIL %s: wait budget expired at cycle %0d (secs=%0d state=%0d)", name, cycle, m_secs, m_st);
    endtask

    task automatic run_until_secs(input int target, input string name);
        int k = 0;
        while (m_secs != target && k < 20000) begin
            idle(1);
            k++;
        end
        if (k >= 20000) bound_fail(name);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            if ({cnt3, cnt2, cnt1, cnt0} === e.dig) n_pass++;
            else $display("FAIL digits @cyc %0d: got %h, expected %h", e.cyc, {cnt3, cnt2, cnt1, cnt0}, e.dig);
            n_checks++;
            if ({running, full, lap_hold} === e.flg) n_pass++;
            else $display("FAIL flags(run,full,hold) @cyc %0d: got %b, expected %b", e.cyc, {running, full, lap_hold}, e.flg);
        end
    end

    initial begin
        int k;
        bit r, s, l, c;

        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);

        // 10 ticks from start
        cyc(0, 1, 0, 0);
        idle(40);

        // Continue through 09:59 -> 10:00 up to saturation at 59:59
        k = 0;
        while (m_st != M_FULL && k < 20000) begin
            idle(1);
            k++;
        end
        if (k >= 20000) bound_fail("reach_full");
        idle(10);
        cyc(0, 1, 0, 0);
        idle(3);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);
        idle(3);

        // Lap freeze and release
        cyc(0, 1, 0, 0);
        run_until_secs(5, "reach_00_05");
        cyc(0, 0, 1, 0);
        idle(32);
        cyc(0, 0, 1, 0);
        idle(2);

        // Pause, clr+start_stop in PAUSE, clr ignored in RUN
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        run_until_secs(3, "reach_00_03");
        cyc(0, 1, 0, 0);
        idle(20);
        cyc(0, 1, 0, 1);
        idle(2);
        cyc(0, 1, 0, 0);
        idle(5);
        cyc(0, 0, 0, 1);
        idle(5);
        cyc(0, 1, 0, 1);
        idle(3);

        // Tick coincident with start_stop at 00:07, then reset mid-run
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        k = 0;
        while (!(m_secs == 7 && m_pre == int'(DIV) - 1) && k < 20000) begin
            idle(1);
            k++;
        end
        if (k >= 20000) bound_fail("reach_00_07_edge");
        cyc(0, 1, 0, 0);
        idle(3);
        cyc(0, 1, 0, 0);
        idle(6);
        cyc(1, 0, 0, 0);
        idle(2);

        // Randomised pulse traffic
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 999) == 0);
            s = ($urandom_range(0, 15) == 0);
            l = ($urandom_range(0, 11) == 0);
            c = ($urandom_range(0, 39) == 0);
            cyc(r, s, l, c);
        end

        #1;
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
